request_arbiter: RTL

REQUEST_ARBITER -- requirements
Module: request_arbiter

---
 rtl/request_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/request_arbiter.sv
// Four-requester round-robin arbiter in front of a single-outstanding shared resource.
// Each requester owns one slot; responses are routed back by ID, and a watchdog aborts a stalled transaction.
module request_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int ADDRESS_WIDTH = 8,
  parameter int ID_WIDTH      = 2,
  parameter int DATA_WIDTH    = 16,
  parameter int TIMEOUT       = 64
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_address,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic [ADDRESS_WIDTH-1:0]         res_address,
  output logic [ID_WIDTH-1:0]              res_id,
  output logic                             res_valid,
  input  logic                             res_ready,
  input  logic [DATA_WIDTH-1:0]            res_data,
  input  logic [ID_WIDTH-1:0]              res_rsp_id,
  input  logic                             res_rsp_valid,
  output logic                             err
);

  localparam int WD_WIDTH = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_WIDTH-1:0] WD_LAST = WD_WIDTH'(TIMEOUT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [1:0]               state;
  logic [NUM_REQ-1:0]       pending;
  logic [ADDRESS_WIDTH-1:0] addr [NUM_REQ];
  logic [ID_WIDTH-1:0]      rr_ptr;
  logic [WD_WIDTH-1:0]      watchdog;

  logic                     grant_found;
  logic [ID_WIDTH-1:0]      grant_idx;
  logic [ID_WIDTH-1:0]      cand;
  logic                     rsp_match;
  logic [NUM_REQ-1:0]       accept;
  logic [NUM_REQ-1:0]       done_mask;

  assign req_ready = ~pending;
  assign res_valid = (state == ISSUE);
  assign accept    = req_valid & ~pending;
  assign rsp_match = res_rsp_valid && (res_rsp_id == res_id);

  // Round-robin search begins one past the last granted requester.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = ID_WIDTH'((32'(rr_ptr) + k) % NUM_REQ);
      if (!grant_found && pending[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Slot of the in-flight requester is released on delivery or on watchdog abort.
  always_comb begin
    done_mask = '0;
    if (state == WAIT && (rsp_match || watchdog == WD_LAST))
      done_mask[res_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pending     <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) addr[i] <= '0;
      rsp_valid   <= '0;
      rsp_data    <= '0;
      res_address <= '0;
      res_id      <= '0;
      rr_ptr      <= ID_WIDTH'(NUM_REQ - 1);
      watchdog    <= '0;
      err         <= 1'b0;
    end else begin
      rsp_valid <= '0;
      pending   <= (pending & ~done_mask) | accept;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (accept[i]) addr[i] <= req_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      end

      case (state)
        IDLE: begin
          if (res_rsp_valid) err <= 1'b1;
          if (res_ready && grant_found) begin
            res_address <= addr[grant_idx];
            res_id      <= grant_idx;
            rr_ptr      <= grant_idx;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (res_rsp_valid) err <= 1'b1;
          watchdog <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          // A matching response wins over a same-cycle watchdog expiry.
          if (rsp_match) begin
            rsp_data          <= res_data;
            rsp_valid[res_id] <= 1'b1;
            watchdog          <= '0;
            state             <= IDLE;
          end else begin
            if (res_rsp_valid) err <= 1'b1;
            if (watchdog == WD_LAST) begin
              err      <= 1'b1;
              watchdog <= '0;
              state    <= IDLE;
            end else begin
              watchdog <= watchdog + WD_WIDTH'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
